// File: rtl/fetch_pkg.sv
// ============================================================================
// fetch_pkg : shared widths and queue entry type for the instruction fetch queue
// Revision  : 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 16;
  localparam logic [ADDR_W-1:0] PC_STEP = 16'd2;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fq_entry_t;

endpackage

`default_nettype wire

// File: rtl/fq_fifo.sv
// ============================================================================
// fq_fifo  : DEPTH-entry circular buffer of {pc, instr} with push/pop/flush
// Revision : 1.0
// ============================================================================
`default_nettype none

module fq_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  fq_entry_t        push_data,
  input  logic             pop,
  output fq_entry_t        head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

  fq_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  // A push into a full buffer is accepted only when the head leaves the same cycle.
  assign w_pop  = pop && (r_count != '0);
  assign w_push = push && ((r_count != C_FULL) || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wr_ptr] <= push_data;
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// fetch_queue : sequential instruction fetch with credit-limited reads, PC
//               shadow, redirect flush/drop. Option: FETCH_QUEUE_BYPASS_EN
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fetch_queue
  import fetch_pkg::*;
#(
  parameter int                DEPTH   = 4,
  parameter int                MEM_LAT = 2,
  parameter logic [ADDR_W-1:0] RST_PC  = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               mem_rreq,
  output logic [ADDR_W-1:0]  mem_raddr,
  input  logic               mem_rvalid,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  input  logic               out_ready
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0] C_DEPTH = (CNT_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [CNT_W-1:0]  r_inflight;
  logic [CNT_W-1:0]  r_drop;
  logic [ADDR_W-1:0] r_shadow [MEM_LAT];
  fq_entry_t         r_hold;

  logic [CNT_W-1:0]  w_count;
  logic [CNT_W:0]    w_used;
  fq_entry_t         w_head;
  fq_entry_t         w_resp;
  fq_entry_t         w_out;
  logic              w_empty;
  logic              w_resp_live;
  logic              w_bypass;
  logic              w_push;
  logic              w_pop;

  // Credits count words already queued plus reads still owed by memory.
  assign w_used    = {1'b0, w_count} + {1'b0, r_inflight};
  assign mem_rreq  = !rst && !redirect_valid && (w_used < C_DEPTH);
  assign mem_raddr = r_fetch_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= RST_PC;
      r_inflight <= '0;
      r_drop     <= '0;
    end else begin
      if (redirect_valid)
        r_fetch_pc <= redirect_pc & ~ADDR_W'(1);
      else if (mem_rreq)
        r_fetch_pc <= r_fetch_pc + PC_STEP;
      r_inflight <= r_inflight + CNT_W'(mem_rreq) - CNT_W'(mem_rvalid);
      if (redirect_valid)
        r_drop <= r_inflight - CNT_W'(mem_rvalid);
      else if (mem_rvalid && (r_drop != '0))
        r_drop <= r_drop - CNT_W'(1);
    end
  end

  // Fixed latency lets a plain delay line pair each response with its address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MEM_LAT; i++) r_shadow[i] <= '0;
    end else begin
      r_shadow[0] <= r_fetch_pc;
      for (int i = 1; i < MEM_LAT; i++) r_shadow[i] <= r_shadow[i-1];
    end
  end

  assign w_resp.pc    = r_shadow[MEM_LAT-1];
  assign w_resp.instr = mem_rdata;
  assign w_resp_live  = mem_rvalid && !redirect_valid && (r_drop == '0);
  assign w_empty      = (w_count == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_bypass = w_empty && w_resp_live;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_out     = w_bypass ? w_resp : w_head;
  assign out_valid = !w_empty || w_bypass;
  assign out_pc    = out_valid ? w_out.pc    : r_hold.pc;
  assign out_instr = out_valid ? w_out.instr : r_hold.instr;
  assign w_pop     = out_valid && out_ready && !w_empty;
  assign w_push    = w_resp_live && !(w_bypass && out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_hold <= '0;
    else if (out_valid) r_hold <= w_out;
  end

  fq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (w_push),
    .push_data (w_resp),
    .pop       (w_pop),
    .head      (w_head),
    .count     (w_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// ============================================================================
// tb_fetch_queue : scoreboard bench for fetch_queue with a fixed-latency memory
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int DEPTH   = 4;
  localparam int MEM_LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        mem_rreq;
  logic [15:0] mem_raddr;
  logic        mem_rvalid = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        out_valid;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic        out_ready = 1'b0;

  always #5 clk = ~clk;

  fetch_queue #(
    .DEPTH   (DEPTH),
    .MEM_LAT (MEM_LAT),
    .RST_PC  (16'h0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_rreq       (mem_rreq),
    .mem_raddr      (mem_raddr),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_ready      (out_ready)
  );

  int          checks   = 0;
  int          failures = 0;
  int          n_pops   = 0;
  fq_entry_t   exp_q [$];
  fq_entry_t   tb_last;
  logic [15:0] exp_addr;
  logic        pv [MEM_LAT];
  logic        pk [MEM_LAT];
  logic [15:0] pa [MEM_LAT];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    for (int i = 0; i < MEM_LAT; i++) begin
      pv[i] = 1'b0; pk[i] = 1'b0; pa[i] = '0;
    end
    exp_addr = 16'h0000;
    tb_last  = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; redirect_valid = 1'b0; mem_rvalid = 1'b0; out_ready = 1'b1;
    #1;
    check_val("rst_rreq",  mem_rreq,  0);
    check_val("rst_valid", out_valid, 0);
    check_val("rst_instr", out_instr, 0);
    check_val("rst_pc",    out_pc,    0);
    clear_model();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One clock: drive memory response and stimulus, then score the settled outputs.
  task automatic cycle(input logic rdy, input logic redir, input logic [15:0] rpc);
    int   infl;
    int   keep_n;
    int   occ;
    logic exp_ov;
    @(negedge clk);
    mem_rvalid     = pv[MEM_LAT-1];
    mem_rdata      = pa[MEM_LAT-1] ^ 16'hA5A5;
    out_ready      = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    #2;
    infl = 0; keep_n = 0;
    for (int i = 0; i < MEM_LAT; i++) begin
      infl   += int'(pv[i]);
      keep_n += int'(pv[i] && pk[i]);
    end
    occ    = exp_q.size() - keep_n;
    exp_ov = (occ > 0);
`ifdef FETCH_QUEUE_BYPASS_EN
    if (occ == 0 && pv[MEM_LAT-1] && pk[MEM_LAT-1] && !redir) exp_ov = 1'b1;
`endif
    check_val("out_valid", out_valid, exp_ov);
    check_val("mem_rreq",  mem_rreq,  !redir && (occ + infl < DEPTH));
    if (out_valid) begin
      check_val("sb_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        check_val("out_pc",    out_pc,    exp_q[0].pc);
        check_val("out_instr", out_instr, exp_q[0].instr);
        tb_last = exp_q[0];
        if (rdy) begin
          void'(exp_q.pop_front());
          n_pops++;
        end
      end
    end else begin
      check_val("hold_pc",    out_pc,    tb_last.pc);
      check_val("hold_instr", out_instr, tb_last.instr);
    end
    if (redir) begin
      exp_q.delete();
      for (int i = 0; i < MEM_LAT; i++) pk[i] = 1'b0;
      exp_addr = rpc & 16'hFFFE;
    end
    if (mem_rreq) begin
      check_val("mem_raddr", mem_raddr, exp_addr);
      exp_q.push_back('{pc: exp_addr, instr: exp_addr ^ 16'hA5A5});
      exp_addr = exp_addr + 16'd2;
    end
    for (int i = MEM_LAT - 1; i > 0; i--) begin
      pv[i] = pv[i-1]; pk[i] = pk[i-1]; pa[i] = pa[i-1];
    end
    pv[0] = mem_rreq; pk[0] = 1'b1; pa[0] = mem_raddr;
  endtask

  initial begin
    int n;
    int exp_lat;
`ifdef FETCH_QUEUE_BYPASS_EN
    exp_lat = MEM_LAT + 1;
`else
    exp_lat = MEM_LAT + 2;
`endif
    clear_model();
    do_reset();

    // In-order streaming with ready held high.
    repeat (30) cycle(1'b1, 1'b0, 16'h0);

    // Backpressure: queue fills, credits run out, then drains.
    repeat (20) cycle(1'b0, 1'b0, 16'h0);
    repeat (10) cycle(1'b1, 1'b0, 16'h0);

    // Redirect with reads in flight, and measure latency to first new word.
    cycle(1'b1, 1'b1, 16'h0100);
    n = 0;
    do begin
      cycle(1'b1, 1'b0, 16'h0);
      n++;
    end while (!out_valid && n < 20);
    check_val("redir_latency", n, exp_lat);
    repeat (10) cycle(1'b1, 1'b0, 16'h0);

    // Odd target address is forced even.
    cycle(1'b1, 1'b1, 16'h0201);
    repeat (10) cycle(1'b1, 1'b0, 16'h0);

    // Back-to-back redirects.
    cycle(1'b1, 1'b1, 16'h0040);
    cycle(1'b1, 1'b1, 16'h0080);
    repeat (15) cycle(1'b1, 1'b0, 16'h0);

    // Address wrap through 16'hFFFE.
    cycle(1'b1, 1'b1, 16'hFFF8);
    repeat (15) cycle(1'b1, 1'b0, 16'h0);

    // Random ready and redirects.
    repeat (300) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
            16'($urandom_range(0, 65535)));
    end

    // Reset pulsed mid-stream.
    repeat (5) cycle(1'b1, 1'b0, 16'h0);
    do_reset();
    repeat (20) cycle(1'b1, 1'b0, 16'h0);

    check_val("pops_seen", n_pops > 150, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
